// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtracter, round-to-nearest-even.
// Optional macro FP_ADDSUB_SPECIALS_EN adds Inf/NaN decode and bypass.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W    = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Output,
    output logic         overflow,
    output logic         inexact
);

    localparam int unsigned FW = MAN_W + 4;   // hidden, frac, guard, round, sticky
    localparam int unsigned EW = EXP_W + 1;   // exponent with headroom for overflow
    localparam int unsigned RW = MAN_W + 2;   // rounded mantissa plus carry
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic w_advance;

    // Stage 1 registers
    logic             r1_valid;
    logic             r1_sign;
    logic             r1_eff_sub;
    logic [EXP_W-1:0] r1_exp;
    logic [FW-1:0]    r1_ml;
    logic [FW-1:0]    r1_ms;
    logic             r1_zero_keep;
    logic             r1_special;
    logic [W-1:0]     r1_spec_word;

    // Stage 2 registers
    logic             r2_valid;
    logic             r2_sign;
    logic [EXP_W-1:0] r2_exp;
    logic [FW:0]      r2_sum;
    logic             r2_zero_keep;
    logic             r2_special;
    logic [W-1:0]     r2_spec_word;

    // Output registers
    logic             r_out_valid;
    logic [W-1:0]     r_output;
    logic             r_overflow;
    logic             r_inexact;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign Output    = r_output;
    assign overflow  = r_overflow;
    assign inexact   = r_inexact;

    // Stage 1: unpack, order by magnitude, align the smaller operand
    logic [EXP_W-1:0] w_ea_f, w_eb_f, w_ea, w_eb, w_el, w_es, w_diff;
    logic [MAN_W:0]   w_ma, w_mb, w_ml, w_ms;
    logic             w_sa, w_sb, w_sl, w_ss, w_a_big, w_zero_keep;
    logic [31:0]      w_shamt;
    logic [2*FW-1:0]  w_ext;
    logic [FW-1:0]    w_s_al;
    logic             w_special;
    logic [W-1:0]     w_spec_word;

    assign w_ea_f = A[W-2:MAN_W];
    assign w_eb_f = B[W-2:MAN_W];
    assign w_ea   = (w_ea_f == '0) ? EXP_W'(1) : w_ea_f;
    assign w_eb   = (w_eb_f == '0) ? EXP_W'(1) : w_eb_f;
    assign w_ma   = {w_ea_f != '0, A[MAN_W-1:0]};
    assign w_mb   = {w_eb_f != '0, B[MAN_W-1:0]};
    assign w_sa   = A[W-1];
    assign w_sb   = B[W-1] ^ op;
    assign w_a_big = {w_ea, w_ma} >= {w_eb, w_mb};
    assign w_zero_keep = (A[W-2:0] == '0) && (B[W-2:0] == '0) && (w_sa == w_sb);

    always_comb begin
        w_el = w_eb;
        w_es = w_ea;
        w_ml = w_mb;
        w_ms = w_ma;
        w_sl = w_sb;
        w_ss = w_sa;
        if (w_a_big) begin
            w_el = w_ea;
            w_es = w_eb;
            w_ml = w_ma;
            w_ms = w_mb;
            w_sl = w_sa;
            w_ss = w_sb;
        end
    end

    assign w_diff  = w_el - w_es;
    assign w_shamt = (32'(w_diff) > FW) ? FW : 32'(w_diff);
    assign w_ext   = {w_ms, 3'b000, {FW{1'b0}}} >> w_shamt;
    assign w_s_al  = {w_ext[2*FW-1:FW+1], w_ext[FW] | (|w_ext[FW-1:0])};

`ifdef FP_ADDSUB_SPECIALS_EN
    logic w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    assign w_a_inf   = (w_ea_f == EXP_ONES) && (A[MAN_W-1:0] == '0);
    assign w_b_inf   = (w_eb_f == EXP_ONES) && (B[MAN_W-1:0] == '0);
    assign w_a_nan   = (w_ea_f == EXP_ONES) && (A[MAN_W-1:0] != '0);
    assign w_b_nan   = (w_eb_f == EXP_ONES) && (B[MAN_W-1:0] != '0);
    assign w_special = (w_ea_f == EXP_ONES) || (w_eb_f == EXP_ONES);

    always_comb begin
        w_spec_word = {w_sb, EXP_ONES, MAN_W'(0)};
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            w_spec_word = {1'b0, EXP_ONES, 1'b1, (MAN_W-1)'(0)};
        else if (w_a_inf)
            w_spec_word = {w_sa, EXP_ONES, MAN_W'(0)};
    end
`else
    assign w_special   = 1'b0;
    assign w_spec_word = '0;
`endif

    // Stage 2: magnitude add or subtract; swap guarantees L >= S
    logic [FW:0] w_sum;
    assign w_sum = r1_eff_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                              : ({1'b0, r1_ml} + {1'b0, r1_ms});

    // Stage 3: normalise, round to nearest even, pack
    logic [31:0]      w_lz, w_lim, w_shl;
    logic [FW-1:0]    w_m;
    logic [EW-1:0]    w_e, w_e_fin;
    logic             w_up, w_ovf, w_inx;
    logic [RW-1:0]    w_rnd;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]     w_res;

    always_comb begin
        w_lz = 32'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (r2_sum[i]) w_lz = 32'(int'(FW) - 1 - i);
        end
    end

    always_comb begin
        w_lim   = 32'(r2_exp) - 32'd1;
        w_shl   = '0;
        w_m     = r2_sum[FW-1:0];
        w_e     = {1'b0, r2_exp};
        w_e_fin = '0;
        w_frac  = w_rnd_frac_default();
        if (r2_sum[FW]) begin
            w_m = {r2_sum[FW:2], r2_sum[1] | r2_sum[0]};
            w_e = {1'b0, r2_exp} + EW'(1);
        end else begin
            w_shl = (w_lz < w_lim) ? w_lz : w_lim;
            w_m   = r2_sum[FW-1:0] << w_shl;
            w_e   = {1'b0, r2_exp} - EW'(w_shl);
        end
        w_inx = |w_m[2:0];
        w_up  = w_m[2] && (w_m[1] || w_m[0] || w_m[3]);
        w_rnd = {1'b0, w_m[FW-1:3]} + RW'(w_up);
        if (w_rnd[RW-1]) begin
            w_e_fin = w_e + EW'(1);
            w_frac  = w_rnd[MAN_W:1];
        end else begin
            w_e_fin = w_rnd[MAN_W] ? w_e : '0;
            w_frac  = w_rnd[MAN_W-1:0];
        end
        w_ovf = w_e_fin >= {1'b0, EXP_ONES};
        w_res = {r2_sign, w_e_fin[EXP_W-1:0], w_frac};
        if (w_ovf)
            w_res = {r2_sign, EXP_ONES, MAN_W'(0)};
        if (r2_sum == '0)
            w_res = {r2_zero_keep && r2_sign, (W-1)'(0)};
        if (r2_special) begin
            w_res = r2_spec_word;
            w_ovf = 1'b0;
            w_inx = 1'b0;
        end
    end

    function automatic logic [MAN_W-1:0] w_rnd_frac_default();
        return '0;
    endfunction

    // Pipeline registers; whole pipe stalls together
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid     <= 1'b0;
            r1_sign      <= 1'b0;
            r1_eff_sub   <= 1'b0;
            r1_exp       <= '0;
            r1_ml        <= '0;
            r1_ms        <= '0;
            r1_zero_keep <= 1'b0;
            r1_special   <= 1'b0;
            r1_spec_word <= '0;
            r2_valid     <= 1'b0;
            r2_sign      <= 1'b0;
            r2_exp       <= '0;
            r2_sum       <= '0;
            r2_zero_keep <= 1'b0;
            r2_special   <= 1'b0;
            r2_spec_word <= '0;
            r_out_valid  <= 1'b0;
            r_output     <= '0;
            r_overflow   <= 1'b0;
            r_inexact    <= 1'b0;
        end else if (w_advance) begin
            r1_valid     <= in_valid;
            r1_sign      <= w_sl;
            r1_eff_sub   <= w_sl ^ w_ss;
            r1_exp       <= w_el;
            r1_ml        <= {w_ml, 3'b000};
            r1_ms        <= w_s_al;
            r1_zero_keep <= w_zero_keep;
            r1_special   <= w_special;
            r1_spec_word <= w_spec_word;
            r2_valid     <= r1_valid;
            r2_sign      <= r1_sign;
            r2_exp       <= r1_exp;
            r2_sum       <= w_sum;
            r2_zero_keep <= r1_zero_keep;
            r2_special   <= r1_special;
            r2_spec_word <= r1_spec_word;
            r_out_valid  <= r2_valid;
            r_output     <= w_res;
            r_overflow   <= w_ovf;
            r_inexact    <= w_inx;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision instance plus a half-precision instance.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, op, out_valid, out_ready, overflow, inexact;
    logic [31:0] A, B, Output;

    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready, h_overflow, h_inexact;
    logic [15:0] h_A, h_B, h_Output;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Output(Output), .overflow(overflow), .inexact(inexact)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .A(h_A), .B(h_B), .op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .Output(h_Output), .overflow(h_overflow), .inexact(h_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated operation: accept, then confirm 3-cycle latency and result
    task automatic op3(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] e, input logic eo, input logic ei);
        A = a; B = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"}, Output, e);
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_inx"}, 32'(inexact), 32'(ei));
    endtask

    logic [31:0] va[4], vb[4], ve[4];
    logic [31:0] held;
    bit          stalled_prev;
    int          sent, got;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; A = '0; B = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_op = 1'b0; h_A = '0; h_B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", Output, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_inx", 32'(inexact), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        op3("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        op3("sub_1p5_0p25", 32'h3FC00000, 32'h3E800000, 1'b1, 32'h3FA00000, 1'b0, 1'b0);
        op3("sub_self",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        op3("neg_result",   32'h3E800000, 32'h3FC00000, 1'b1, 32'hBFA00000, 1'b0, 1'b0);
        op3("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b1);
        op3("round_up",     32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b1);
        op3("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        op3("cancel_norm",  32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0);
        op3("subnorm_add",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
        op3("far_sticky",   32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 1'b1);
        op3("neg_zeros",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);
        op3("zero_minus_0", 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
`ifdef FP_ADDSUB_SPECIALS_EN
        op3("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
        op3("nan_in",        32'h7F800123, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
        op3("inf_plus_fin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
`else
        op3("allones_sub",   32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
`endif

        // Drain the last result before streaming
        @(posedge clk); #1;
        chk("drained", 32'(out_valid), 32'd0);

        va[0] = 32'h3F800000; vb[0] = 32'h3F800000; ve[0] = 32'h40000000;
        va[1] = 32'h40000000; vb[1] = 32'h40000000; ve[1] = 32'h40800000;
        va[2] = 32'h3F800000; vb[2] = 32'h3F000000; ve[2] = 32'h3FC00000;
        va[3] = 32'h3FC00000; vb[3] = 32'hBE800000; ve[3] = 32'h3FA00000;
        sent = 0; got = 0; stalled_prev = 1'b0; held = '0; op = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 4);
            A = va[(sent < 4) ? sent : 3];
            B = vb[(sent < 4) ? sent : 3];
            #1;
            if (stalled_prev) chk("stall_hold", Output, held);
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                held = Output;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d", got), Output, ve[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 32'(got), 32'd4);
        chk("stream_sent", 32'(sent), 32'd4);
        #1;
        chk("no_duplicate", 32'(out_valid), 32'd0);

        // Mid-stream reset discards everything in flight
        A = 32'h3F800000; B = 32'h3F800000; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_out", Output, 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_flushed", 32'(out_valid), 32'd0);

        // Half-precision instance
        h_A = 16'h3C00; h_B = 16'h3C00; h_op = 1'b0; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("half_valid", 32'(h_out_valid), 32'd1);
        chk("half_out", 32'(h_Output), 32'h00004000);
        chk("half_flags", {30'd0, h_overflow, h_inexact}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder/subtracter. It is the successor to the single-precision combinational adder in the ALU. It adds generic exponent and mantissa widths, an add/sub opcode, a 3-stage pipeline with valid/ready flow control, round-to-nearest-even, and overflow/inexact flags. It sits between the ALU operand registers and the result writeback mux.

Parameters:
EXP_W, 8, exponent field width (bits)
MAN_W, 23, stored mantissa (fraction) width, hidden bit excluded
W, EXP_W+MAN_W+1, total word width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  A/B/op present this cycle
in_ready  out  1  stage 1 can accept this cycle
A  in  W  operand A {sign, exp, frac}
B  in  W  operand B
op  in  1  0 = A+B, 1 = A-B (invert B sign at capture)
out_valid  out  1  Output/flags valid
out_ready  in  1  consumer accepts Output this cycle
Output  out  W  result {sign, exp, frac}
overflow  out  1  result exponent saturated to all-ones
inexact  out  1  any guard/round/sticky bit was nonzero

Behaviour:
- Reset (synchronous): all stage valid bits = 0. out_valid=0, Output=0, overflow=0, inexact=0. in_ready=1 in the first cycle after reset deasserts. Reset mid-operation discards all in-flight items.
- Flow control: advance = !out_valid | out_ready; in_ready = advance (whole-pipe stall).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- When stalled, every stage register holds and Output/flags stay stable.
- Latency: exactly 3 cycles from accepted input to out_valid with no stalls. Throughput is 1 result per cycle.
- Bubbles (in_valid=0 while advancing) propagate as valid=0.
- Stage 1 (unpack/align):
  - Exp field 0 → exponent 1 with hidden bit 0 (subnormal). Otherwise hidden bit 1.
  - Effective sign_B = B[W-1] ^ op.
  - Swap so operand L has the larger exponent; on a tie, the larger mantissa.
  - Shift the smaller mantissa right by the exponent difference into an MAN_W+4 field (hidden, frac, guard, round, sticky).
  - Sticky = OR of all bits shifted beyond the field. A difference ≥ MAN_W+3 leaves only sticky.
- Stage 2 (add/sub): equal effective signs → add; otherwise L − S, which is never negative after the swap. Result sign = L sign. Keep the carry bit.
- Stage 3 (normalise/round):
  - Carry out → shift right 1, OR the dropped bit into sticky, exponent +1.
  - Otherwise leading-zero count → shift left until the hidden bit is set, limited so the exponent does not go below 1. If still unnormalised, emit exp field 0 (subnormal).
  - Round to nearest even on {guard, round|sticky}.
  - If rounding overflows the mantissa → shift right 1, exponent +1.
  - inexact = guard|round|sticky before rounding.
- Exact zero result: Output = +0 (sign 0), unless both inputs are zero with the same effective sign, in which case that sign is kept.
- Overflow: final exponent ≥ 2^EXP_W − 1 → exp field all ones, fraction 0, overflow=1 (signed infinity).
- Flags are registered alongside Output and are valid only while out_valid=1.

Optional Feature:
FP_ADDSUB_SPECIALS_EN
- Defined: inputs with exp field all ones are decoded in stage 1 and bypass the arithmetic path with matching latency.
  - NaN in → canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0).
  - Inf + (−Inf) effective → quiet NaN.
  - Inf ± finite → that Inf.
  - Flags are 0 for all special results.
- Undefined: exp all-ones inputs are treated as ordinary normal numbers; there is no NaN decode and no extra logic.

Test Plan:
1. A=0x3F800000, B=0x3F800000, op=0 → Output 0x40000000 three cycles later; overflow=0, inexact=0.
2. A=0x3FC00000, B=0x3E800000, op=1 → 0x3FA00000 (1.5−0.25=1.25). Also A=B=0x3F800000, op=1 → 0x00000000.
3. A=0x3F800000, B=0x33800000 (2^-24 tie), op=0 → 0x3F800000, inexact=1. Same A with B=0x33C00000 → 0x3F800001, inexact=1.
4. A=B=0x7F7FFFFF, op=0 → 0x7F800000, overflow=1.
5. Back-to-back: stream 4 operand pairs with out_ready held 0 for cycles 4–6. Required: in_ready=0 while the pipe is full, Output held stable, all 4 results delivered in order with none dropped or duplicated. Assert reset mid-stream → out_valid=0 next cycle.
6. Non-default EXP_W=5, MAN_W=10 (half): A=0x3C00, B=0x3C00, op=0 → 0x4000. With FP_ADDSUB_SPECIALS_EN: A=0x7F800000, B=0x7F800000, op=1 → 0x7FC00000.
